// File: rtl/comm_defs_pkg.sv
// comm_defs_pkg: definitions shared by the front-end arbiter.
//   ASCII_0          - ASCII '0', used to build the idle/"no error" code
//   TMO_W            - width of the watchdog counter and limit
//   MODE_*           - arbitration policy encodings for frontarb.mode
//   frontarb_state_t - arbiter FSM states
//   xact_t           - one captured transaction (address, data, flags, code)
//   pick_scan()      - owner selection for a given policy and pending set
package comm_defs_pkg;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam int TMO_W = 16;

  localparam logic [1:0] MODE_RR     = 2'b00;
  localparam logic [1:0] MODE_UART   = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RR_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } frontarb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        we;
    logic        decode_err;
    logic [15:0] err_code;
  } xact_t;

  localparam xact_t XACT_RESET = '{
    addr:       32'h0,
    wrdata:     32'h0,
    we:         1'b0,
    decode_err: 1'b0,
    err_code:   {ASCII_0, ASCII_0}
  };

  // Returns 1 when scan should own the backend. Only meaningful when at
  // least one requester is pending; a lone pending requester always wins.
  function automatic logic pick_scan(input logic [1:0] mode,
                                     input logic       pend_uart,
                                     input logic       pend_scan,
                                     input logic       last_scan);
    logic sel;
    sel = pend_scan;
    if (pend_uart && pend_scan) begin
      case (mode)
        MODE_UART: sel = 1'b0;
        MODE_SCAN: sel = 1'b1;
        default:   sel = !last_scan;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/frontarb_slot.sv
// frontarb_slot: single-entry pending slot for one requester.
//   clk, rstn - clock, async active-low reset
//   start     - request pulse; captures din when the slot is free
//   din       - transaction fields presented with start
//   take      - arbiter grants this slot this cycle (frees it)
//   pend      - slot holds a transaction not yet granted
//   dout      - the held transaction
//   ovf       - registered pulse: a request was dropped because the slot was full
module frontarb_slot
  import comm_defs_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  start,
  input  xact_t din,
  input  logic  take,
  output logic  pend,
  output xact_t dout,
  output logic  ovf
);

  // A slot being granted this cycle counts as free, so a back-to-back
  // request is captured instead of dropped.
  logic can_capture;
  assign can_capture = !pend || take;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 1'b0;
      dout <= XACT_RESET;
      ovf  <= 1'b0;
    end else begin
      ovf <= start && !can_capture;
      if (start && can_capture) begin
        pend <= 1'b1;
        dout <= din;
      end else if (take) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/frontarb.sv
// frontarb: arbitrates UART and scan transaction requests onto one backend.
//   clk, rstn                 - clock, async active-low reset
//   mode                      - 00/11 round-robin, 01 UART priority, 10 scan priority
//   sm_start_uart, addr_uart, wrdata_uart, we_uart, decode_err_uart, err_code_uart
//                             - UART request pulse and fields
//   sm_start_scan, addr_scan, wrdata_scan, we_scan
//                             - scan request pulse and fields
//   bk_done                   - backend finished the current transaction
//   tmo_limit                 - watchdog limit in cycles (0 = off)
//   tmo_clr                   - clears tmo_err
//   sm_start                  - one-cycle start pulse to the backend
//   addr, wrdata, we, decode_err, err_code
//                             - fields of the granted transaction, held until next grant
//   scanxfer                  - scan owns the backend
//   grant_uart, grant_scan    - pulse when that requester is granted
//   busy                      - arbiter not idle
//   ovf_uart, ovf_scan        - pulse when a request is dropped
//   tmo_err                   - sticky watchdog flag
//   state_dbg                 - current FSM state
//
// Handshake: a request is a single-cycle sm_start_x pulse with its fields
// valid in that cycle; there is no ready, so a request arriving while the
// slot is still full is dropped and reported on ovf_x. Toward the backend,
// sm_start marks the cycle the held fields become a new transaction and
// bk_done (honoured only while waiting) ends it.
module frontarb
  import comm_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            mode,
  input  logic                  sm_start_uart,
  input  logic [31:0]           addr_uart,
  input  logic [31:0]           wrdata_uart,
  input  logic                  we_uart,
  input  logic                  decode_err_uart,
  input  logic [15:0]           err_code_uart,
  input  logic                  sm_start_scan,
  input  logic [31:0]           addr_scan,
  input  logic [31:0]           wrdata_scan,
  input  logic                  we_scan,
  input  logic                  bk_done,
  input  logic [TMO_W-1:0]      tmo_limit,
  input  logic                  tmo_clr,
  output logic                  sm_start,
  output logic [31:0]           addr,
  output logic [31:0]           wrdata,
  output logic                  we,
  output logic                  decode_err,
  output logic [15:0]           err_code,
  output logic                  scanxfer,
  output logic                  grant_uart,
  output logic                  grant_scan,
  output logic                  busy,
  output logic                  ovf_uart,
  output logic                  ovf_scan,
  output logic                  tmo_err,
  output frontarb_state_t       state_dbg
);

  frontarb_state_t  state;
  logic             owner_scan;
  logic             last_scan;
  logic [TMO_W-1:0] cnt;
  xact_t            out_x;

  xact_t uart_in, scan_in, uart_q, scan_q;
  logic  pend_uart, pend_scan;
  logic  do_grant, sel_scan, take_uart, take_scan;

  assign uart_in = '{addr: addr_uart, wrdata: wrdata_uart, we: we_uart,
                     decode_err: decode_err_uart, err_code: err_code_uart};
  // Scan never reports a decode error; its code is always the "00" idle code.
  assign scan_in = '{addr: addr_scan, wrdata: wrdata_scan, we: we_scan,
                     decode_err: 1'b0, err_code: {ASCII_0, ASCII_0}};

  assign do_grant  = (state == ST_IDLE) && (pend_uart || pend_scan);
  assign sel_scan  = pick_scan(mode, pend_uart, pend_scan, last_scan);
  assign take_uart = do_grant && !sel_scan;
  assign take_scan = do_grant && sel_scan;

  frontarb_slot u_slot_uart (
    .clk   (clk),
    .rstn  (rstn),
    .start (sm_start_uart),
    .din   (uart_in),
    .take  (take_uart),
    .pend  (pend_uart),
    .dout  (uart_q),
    .ovf   (ovf_uart)
  );

  frontarb_slot u_slot_scan (
    .clk   (clk),
    .rstn  (rstn),
    .start (sm_start_scan),
    .din   (scan_in),
    .take  (take_scan),
    .pend  (pend_scan),
    .dout  (scan_q),
    .ovf   (ovf_scan)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      owner_scan <= 1'b0;
      last_scan  <= 1'b1;
      cnt        <= '0;
      out_x      <= XACT_RESET;
      sm_start   <= 1'b0;
      grant_uart <= 1'b0;
      grant_scan <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      sm_start   <= 1'b0;
      grant_uart <= 1'b0;
      grant_scan <= 1'b0;
      // A timeout below overrides this clear in the same cycle.
      if (tmo_clr) tmo_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            state      <= ST_ISSUE;
            owner_scan <= sel_scan;
            last_scan  <= sel_scan;
            out_x      <= sel_scan ? scan_q : uart_q;
            grant_uart <= !sel_scan;
            grant_scan <= sel_scan;
          end
        end
        ST_ISSUE: begin
          sm_start <= 1'b1;
          cnt      <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // bk_done is checked first so it beats a coincident timeout.
          if (bk_done) begin
            state <= ST_IDLE;
          end else if ((tmo_limit != '0) && (cnt == tmo_limit - TMO_W'(1))) begin
            tmo_err <= 1'b1;
            state   <= ST_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign scanxfer   = busy && owner_scan;
  assign addr       = out_x.addr;
  assign wrdata     = out_x.wrdata;
  assign we         = out_x.we;
  assign decode_err = out_x.decode_err;
  assign err_code   = out_x.err_code;
  assign state_dbg  = state;

endmodule

// File: tb/tb_frontarb.sv
module tb_frontarb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  mode = 2'b00;
  logic        sm_start_uart = 0, we_uart = 0, decode_err_uart = 0;
  logic [31:0] addr_uart = 0, wrdata_uart = 0;
  logic [15:0] err_code_uart = 0;
  logic        sm_start_scan = 0, we_scan = 0;
  logic [31:0] addr_scan = 0, wrdata_scan = 0;
  logic        bk_done = 0, tmo_clr = 0;
  logic [15:0] tmo_limit = 0;

  logic        sm_start, we, decode_err, scanxfer, grant_uart, grant_scan;
  logic        busy, ovf_uart, ovf_scan, tmo_err;
  logic [31:0] addr, wrdata;
  logic [15:0] err_code;
  comm_defs_pkg::frontarb_state_t state_dbg;

  frontarb dut (
    .clk(clk), .rstn(rstn), .mode(mode),
    .sm_start_uart(sm_start_uart), .addr_uart(addr_uart), .wrdata_uart(wrdata_uart),
    .we_uart(we_uart), .decode_err_uart(decode_err_uart), .err_code_uart(err_code_uart),
    .sm_start_scan(sm_start_scan), .addr_scan(addr_scan), .wrdata_scan(wrdata_scan),
    .we_scan(we_scan), .bk_done(bk_done), .tmo_limit(tmo_limit), .tmo_clr(tmo_clr),
    .sm_start(sm_start), .addr(addr), .wrdata(wrdata), .we(we), .decode_err(decode_err),
    .err_code(err_code), .scanxfer(scanxfer), .grant_uart(grant_uart),
    .grant_scan(grant_scan), .busy(busy), .ovf_uart(ovf_uart), .ovf_scan(ovf_scan),
    .tmo_err(tmo_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Requester index: 0 = UART, 1 = scan. The transfer is tracked as the number
  // of cycles since its grant: 0 = no transfer, 1 = granted, 2 = waiting on backend.
  logic        m_pend[2];
  logic [31:0] s_addr[2], s_wd[2];
  logic        s_we[2], s_de[2];
  logic [15:0] s_ec[2];
  int          m_age, m_owner, m_last;
  int unsigned m_wait;
  logic        m_tmo;

  logic        e_sm_start, e_grant_u, e_grant_s, e_ovf_u, e_ovf_s;
  logic [31:0] e_addr, e_wd;
  logic        e_we, e_de;
  logic [15:0] e_ec;

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_age = 0; m_owner = 0; m_last = 1; m_wait = 0; m_tmo = 0;
    e_sm_start = 0; e_grant_u = 0; e_grant_s = 0; e_ovf_u = 0; e_ovf_s = 0;
    e_addr = 0; e_wd = 0; e_we = 0; e_de = 0; e_ec = 16'h3030;
  endtask

  function automatic int pick_owner();
    if (m_pend[0] && !m_pend[1]) return 0;
    if (m_pend[1] && !m_pend[0]) return 1;
    if (mode == 2'b01) return 0;
    if (mode == 2'b10) return 1;
    return 1 - m_last;
  endfunction

  task automatic model_edge();
    int g;
    g = -1;
    if (m_age == 0 && (m_pend[0] || m_pend[1])) g = pick_owner();
    e_ovf_u    = sm_start_uart && m_pend[0] && (g != 0);
    e_ovf_s    = sm_start_scan && m_pend[1] && (g != 1);
    e_grant_u  = (g == 0);
    e_grant_s  = (g == 1);
    e_sm_start = (m_age == 1);
    if (g >= 0) begin
      e_addr = s_addr[g]; e_wd = s_wd[g]; e_we = s_we[g]; e_de = s_de[g]; e_ec = s_ec[g];
    end
    if (sm_start_uart && (!m_pend[0] || g == 0)) begin
      m_pend[0] = 1; s_addr[0] = addr_uart; s_wd[0] = wrdata_uart;
      s_we[0] = we_uart; s_de[0] = decode_err_uart; s_ec[0] = err_code_uart;
    end else if (g == 0) m_pend[0] = 0;
    if (sm_start_scan && (!m_pend[1] || g == 1)) begin
      m_pend[1] = 1; s_addr[1] = addr_scan; s_wd[1] = wrdata_scan;
      s_we[1] = we_scan; s_de[1] = 0; s_ec[1] = 16'h3030;
    end else if (g == 1) m_pend[1] = 0;
    if (tmo_clr) m_tmo = 0;
    if (m_age == 0) begin
      if (g >= 0) begin m_age = 1; m_owner = g; m_last = g; end
    end else if (m_age == 1) begin
      m_age = 2; m_wait = 0;
    end else begin
      if (bk_done) m_age = 0;
      else if (tmo_limit != 0 && m_wait == int'(tmo_limit) - 1) begin m_tmo = 1; m_age = 0; end
      else if (m_wait < 65535) m_wait++;
    end
  endtask

  task automatic compare_all();
    check("sm_start",   64'(sm_start),   64'(e_sm_start));
    check("grant_uart", 64'(grant_uart), 64'(e_grant_u));
    check("grant_scan", 64'(grant_scan), 64'(e_grant_s));
    check("ovf_uart",   64'(ovf_uart),   64'(e_ovf_u));
    check("ovf_scan",   64'(ovf_scan),   64'(e_ovf_s));
    check("busy",       64'(busy),       64'(m_age != 0));
    check("scanxfer",   64'(scanxfer),   64'(m_age != 0 && m_owner == 1));
    check("tmo_err",    64'(tmo_err),    64'(m_tmo));
    check("addr",       64'(addr),       64'(e_addr));
    check("wrdata",     64'(wrdata),     64'(e_wd));
    check("we",         64'(we),         64'(e_we));
    check("decode_err", 64'(decode_err), 64'(e_de));
    check("err_code",   64'(err_code),   64'(e_ec));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk); #1;
    compare_all();
    if (grant_uart) got_q.push_back(2'd0);
    if (grant_scan) got_q.push_back(2'd1);
  endtask

  task automatic clear_pulses();
    sm_start_uart = 0; sm_start_scan = 0; bk_done = 0; tmo_clr = 0;
  endtask

  task automatic req_uart(input logic [31:0] a, input logic [31:0] d);
    sm_start_uart = 1; addr_uart = a; wrdata_uart = d;
    we_uart = 1; decode_err_uart = 0; err_code_uart = 16'h3030;
  endtask

  task automatic req_scan(input logic [31:0] a, input logic [31:0] d);
    sm_start_scan = 1; addr_scan = a; wrdata_scan = d; we_scan = 0;
  endtask

  // Completes transfers by answering every sm_start with bk_done next cycle.
  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) begin
      bk_done = sm_start;
      step();
    end
    bk_done = 0;
  endtask

  // Steps until sm_start is seen; an expired budget is a failed comparison.
  task automatic wait_sm_start(input int budget);
    int k;
    k = 0;
    while (!sm_start && k < budget) begin step(); k++; end
    if (!sm_start) check("sm_start_wait", 64'(k), 64'(budget + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    compare_all();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;

    // UART only: two cycles from request to sm_start
    req_uart(32'h10, 32'hA5);
    step(); clear_pulses();
    step();
    check("dir_grant_uart", 64'(grant_uart), 64'd1);
    check("dir_addr", 64'(addr), 64'h10);
    step();
    check("dir_sm_start", 64'(sm_start), 64'd1);
    check("dir_scanxfer", 64'(scanxfer), 64'd0);
    run_auto(4);

    // Reset so round-robin begins from its reset history
    rstn = 0; #1; model_reset(); compare_all();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;

    // Simultaneous requests in round-robin mode, four rounds
    mode = 2'b00;
    got_q.delete(); exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      req_uart(32'h1000 + 32'(r), $urandom);
      req_scan(32'h2000 + 32'(r), $urandom);
      step(); clear_pulses();
      run_auto(10);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    end
    check("rr_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rr_order", 64'(got_q[i]), 64'(exp_q[i]));

    // Overflow on scan while its slot is full; first scan data survives
    req_uart(32'h100, 32'h1);
    step(); clear_pulses();
    wait_sm_start(4);
    req_scan(32'h200, 32'h22); step(); clear_pulses();
    req_scan(32'h300, 32'h33); step(); clear_pulses();
    check("dir_ovf_scan", 64'(ovf_scan), 64'd1);
    bk_done = 1; step(); bk_done = 0;
    step();
    check("dir_ovf_grant", 64'(grant_scan), 64'd1);
    check("dir_ovf_addr", 64'(addr), 64'h200);
    run_auto(4);

    // Watchdog timeout after 8 waiting cycles, then clear
    tmo_limit = 16'd8;
    req_uart(32'h400, 32'h4); step(); clear_pulses();
    wait_sm_start(4);
    for (int i = 0; i < 7; i++) step();
    check("tmo_before", 64'(tmo_err), 64'd0);
    step();
    check("tmo_set", 64'(tmo_err), 64'd1);
    check("tmo_idle", 64'(busy), 64'd0);
    tmo_clr = 1; step(); clear_pulses();
    check("tmo_cleared", 64'(tmo_err), 64'd0);

    // bk_done coinciding with the timeout cycle wins
    req_uart(32'h500, 32'h5); step(); clear_pulses();
    wait_sm_start(4);
    for (int i = 0; i < 7; i++) step();
    bk_done = 1; step(); bk_done = 0;
    check("tmo_vs_done", 64'(tmo_err), 64'd0);
    check("done_idle", 64'(busy), 64'd0);

    // Reset during a wait: everything back to reset values, no reissue
    tmo_limit = 0;
    req_scan(32'h600, 32'h6); step(); clear_pulses();
    wait_sm_start(4);
    step();
    #2 rstn = 0; #1;
    model_reset();
    compare_all();
    @(posedge clk); @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: tmo_limit = 16'd0;
          1: tmo_limit = 16'd2;
          2: tmo_limit = 16'd4;
          default: tmo_limit = 16'd9;
        endcase
      end
      mode          = 2'($urandom_range(0, 3));
      sm_start_uart = ($urandom_range(0, 3) == 0);
      addr_uart     = $urandom; wrdata_uart = $urandom;
      we_uart       = 1'($urandom_range(0, 1));
      decode_err_uart = 1'($urandom_range(0, 1));
      err_code_uart = 16'($urandom);
      sm_start_scan = ($urandom_range(0, 3) == 0);
      addr_scan     = $urandom; wrdata_scan = $urandom;
      we_scan       = 1'($urandom_range(0, 1));
      bk_done       = ($urandom_range(0, 4) == 0);
      tmo_clr       = ($urandom_range(0, 9) == 0);
      step();
    end
    clear_pulses();
    run_auto(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
